// File: rtl/ads122c04_ain_averager.sv
// ads122c04_ain_averager
//
// Boxcar averager for the four AIN result registers of the ADS122C04 I2C
// controller. A conversion is considered complete when the controller's
// channel-sequencer index (i_ain_sm) steps; the channel just left is the one
// whose result register now holds a fresh 24-bit code. Codes are
// sign-extended and 2^k consecutive samples per channel are summed. The
// per-channel average (sum >>> k, floor toward -inf) is published as a
// signed 32-bit value.
//
// Ports
//   i_clk, i_rst_n          100 MHz system clock, async active-low reset
//   i_ain_sm[1:0]           controller channel index (i2c_clk domain, synced)
//   i_AIN0..i_AIN3[31:0]    controller results, only [23:0] used (quasi-static)
//   i_avg_log2[2:0]         averaging exponent k, clamped to LOG2_MAX
//   i_clear                 level: flush partial sums, clear o_seq_err
//   o_avg0..o_avg3[31:0]    signed averaged results
//   o_valid, o_ch[1:0]      one-cycle strobe + channel of the updated result
//   o_seq_err               sticky out-of-order channel step flag
//   o_sample_cnt[15:0]      accepted-sample counter, wraps
//   o_stall                 watchdog flag
//
// Result strobe: o_valid is a single-cycle pulse with no back-pressure; on
// the cycle it is high, o_ch names the channel and o_avg<o_ch> already holds
// the new value. There is no ready; a consumer must sample it that cycle.
//
// Optional build macro AIN_STALL_DET_EN enables the no-conversion watchdog
// (STALL_CYCLES i_clk cycles without any channel step raises o_stall).
// Without it o_stall is constant 0.
module ads122c04_ain_averager #(
  parameter int          LOG2_MAX     = 4,
  parameter logic [31:0] STALL_CYCLES = 32'd5_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_ain_sm,
  input  logic [31:0] i_AIN0,
  input  logic [31:0] i_AIN1,
  input  logic [31:0] i_AIN2,
  input  logic [31:0] i_AIN3,
  input  logic [2:0]  i_avg_log2,
  input  logic        i_clear,
  output logic [31:0] o_avg0,
  output logic [31:0] o_avg1,
  output logic [31:0] o_avg2,
  output logic [31:0] o_avg3,
  output logic        o_valid,
  output logic [1:0]  o_ch,
  output logic        o_seq_err,
  output logic [15:0] o_sample_cnt,
  output logic        o_stall
);

  localparam int         AW    = 24 + LOG2_MAX;
  localparam int         CW    = LOG2_MAX + 1;
  localparam logic [2:0] K_MAX = 3'(LOG2_MAX);

  logic [1:0]           sm_s1, sm_s2, sm_prev;
  logic [2:0]           k_in, k_q;
  logic                 evt, legal, k_chg, hit;
  logic [23:0]          code;
  logic signed [AW-1:0] x, acc_total;
  logic signed [AW-1:0] acc [4];
  logic [CW-1:0]        cnt [4];
  logic [CW-1:0]        cnt_next, target;

  // Second stage: a completed window waiting to be scaled and published.
  logic                 res_go;
  logic [1:0]           res_ch;
  logic [2:0]           res_k;
  logic signed [AW-1:0] res_acc, res_shift;
  logic [31:0]          res_ext;

  always_comb begin
    k_in  = (i_avg_log2 > K_MAX) ? K_MAX : i_avg_log2;
    k_chg = (k_in != k_q);
    evt   = (sm_s2 != sm_prev);
    legal = (sm_s2 == (sm_prev + 2'd1));

    // The completed channel is the one the sequencer has just left.
    code = i_AIN0[23:0];
    case (sm_prev)
      2'd1:    code = i_AIN1[23:0];
      2'd2:    code = i_AIN2[23:0];
      2'd3:    code = i_AIN3[23:0];
      default: code = i_AIN0[23:0];
    endcase

    x         = {{(AW-24){code[23]}}, code};
    acc_total = acc[sm_prev] + x;
    cnt_next  = cnt[sm_prev] + CW'(1);
    target    = CW'(1) << k_q;
    hit       = (cnt_next == target);

    // Arithmetic shift of a signed sum floors toward -inf.
    res_shift = res_acc >>> res_k;
    res_ext   = {{(32-AW){res_shift[AW-1]}}, res_shift};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sm_s1        <= '0;
      sm_s2        <= '0;
      sm_prev      <= '0;
      k_q          <= '0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      res_go       <= 1'b0;
      res_ch       <= '0;
      res_k        <= '0;
      res_acc      <= '0;
      o_avg0       <= '0;
      o_avg1       <= '0;
      o_avg2       <= '0;
      o_avg3       <= '0;
      o_valid      <= 1'b0;
      o_ch         <= '0;
      o_seq_err    <= 1'b0;
      o_sample_cnt <= '0;
    end else begin
      sm_s1   <= i_ain_sm;
      sm_s2   <= sm_s1;
      sm_prev <= sm_s2;
      k_q     <= k_in;
      res_go  <= 1'b0;

      // A clear or an exponent change discards any event seen this cycle so
      // that no window ever mixes samples taken under different k.
      if (i_clear || k_chg) begin
        for (int i = 0; i < 4; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
        if (i_clear) o_seq_err <= 1'b0;
      end else if (evt) begin
        if (legal) begin
          o_sample_cnt <= o_sample_cnt + 16'd1;
          if (hit) begin
            acc[sm_prev] <= '0;
            cnt[sm_prev] <= '0;
            res_go       <= 1'b1;
            res_ch       <= sm_prev;
            res_k        <= k_q;
            res_acc      <= acc_total;
          end else begin
            acc[sm_prev] <= acc_total;
            cnt[sm_prev] <= cnt_next;
          end
        end else begin
          o_seq_err <= 1'b1;
        end
      end

      o_valid <= res_go;
      if (res_go) begin
        o_ch <= res_ch;
        case (res_ch)
          2'd1:    o_avg1 <= res_ext;
          2'd2:    o_avg2 <= res_ext;
          2'd3:    o_avg3 <= res_ext;
          default: o_avg0 <= res_ext;
        endcase
      end
    end
  end

  logic unused_ain_hi;
  assign unused_ain_hi = ^{i_AIN0[31:24], i_AIN1[31:24], i_AIN2[31:24], i_AIN3[31:24]};

`ifdef AIN_STALL_DET_EN
  logic [31:0] stall_cnt;

  // Any channel step, legal or not, proves the controller is alive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      o_stall   <= 1'b0;
    end else begin
      if (evt || i_clear) stall_cnt <= '0;
      else if (stall_cnt != STALL_CYCLES) stall_cnt <= stall_cnt + 32'd1;

      if (evt) o_stall <= 1'b0;
      else if (stall_cnt == STALL_CYCLES) o_stall <= 1'b1;
    end
  end
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^STALL_CYCLES;
  assign o_stall = 1'b0;
`endif

endmodule

// File: tb/tb_ads122c04_ain_averager.sv
// Testbench for ads122c04_ain_averager: directed test-plan steps followed by
// randomized channel steps, codes and exponents, checked against a
// window-of-samples reference model.
module tb_ads122c04_ain_averager;

  localparam int LOG2_MAX = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  i_ain_sm;
  logic [31:0] i_AIN0, i_AIN1, i_AIN2, i_AIN3;
  logic [2:0]  i_avg_log2;
  logic        i_clear;
  logic [31:0] o_avg0, o_avg1, o_avg2, o_avg3;
  logic        o_valid;
  logic [1:0]  o_ch;
  logic        o_seq_err;
  logic [15:0] o_sample_cnt;
  logic        o_stall;

  always #5 clk = ~clk;

  ads122c04_ain_averager #(.LOG2_MAX(LOG2_MAX), .STALL_CYCLES(32'd100)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ain_sm(i_ain_sm),
    .i_AIN0(i_AIN0), .i_AIN1(i_AIN1), .i_AIN2(i_AIN2), .i_AIN3(i_AIN3),
    .i_avg_log2(i_avg_log2), .i_clear(i_clear),
    .o_avg0(o_avg0), .o_avg1(o_avg1), .o_avg2(o_avg2), .o_avg3(o_avg3),
    .o_valid(o_valid), .o_ch(o_ch), .o_seq_err(o_seq_err),
    .o_sample_cnt(o_sample_cnt), .o_stall(o_stall)
  );

  // ---------------- reference model / scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [1:0]  m_sm;
  int          m_k;
  logic [15:0] m_cnt;
  logic        m_err;
  logic [31:0] exp_avg [4];
  longint      win [4][$];
  logic [33:0] exp_q [$];   // {channel, average}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int clamp_k(input int v);
    return (v > LOG2_MAX) ? LOG2_MAX : v;
  endfunction

  function automatic logic [31:0] dut_avg(input logic [1:0] c);
    case (c)
      2'd1:    return o_avg1;
      2'd2:    return o_avg2;
      2'd3:    return o_avg3;
      default: return o_avg0;
    endcase
  endfunction

  task automatic model_flush();
    for (int c = 0; c < 4; c++) win[c].delete();
  endtask

  task automatic model_reset();
    model_flush();
    for (int c = 0; c < 4; c++) exp_avg[c] = '0;
    m_sm  = 2'd0;
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  // Completed channel is the one being left; only a +1 step is a sample.
  task automatic model_event(input logic [1:0] nsm, input logic [23:0] code);
    logic [1:0] nxt;
    longint     v, sum, q;
    int         n, c;
    nxt = m_sm + 2'd1;
    if (nsm != nxt) begin
      m_err = 1'b1;
    end else begin
      c = int'(m_sm);
      v = longint'(code);
      if (code[23]) v = v - 64'sd16777216;
      win[c].push_back(v);
      m_cnt = m_cnt + 16'd1;
      n = 1 << m_k;
      if (win[c].size() == n) begin
        sum = 0;
        foreach (win[c][i]) sum += win[c][i];
        q = sum / n;
        if ((sum % n) != 0 && sum < 0) q = q - 1;
        exp_avg[c] = q[31:0];
        exp_q.push_back({m_sm, q[31:0]});
        win[c].delete();
      end
    end
    m_sm = nsm;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ain(input logic [1:0] ch, input logic [23:0] code);
    logic [7:0] junk;
    junk = 8'($urandom);
    case (ch)
      2'd1:    i_AIN1 = {junk, code};
      2'd2:    i_AIN2 = {junk, code};
      2'd3:    i_AIN3 = {junk, code};
      default: i_AIN0 = {junk, code};
    endcase
  endtask

  task automatic send_event(input logic [1:0] nsm, input logic [23:0] code);
    logic [33:0] e;
    @(negedge clk);
    set_ain(m_sm, code);
    i_ain_sm = nsm;
    model_event(nsm, code);
    repeat (3) @(posedge clk);
    #1;
    chk("valid_early", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid", 32'(o_valid), 32'd1);
      chk("ch", 32'(o_ch), 32'(e[33:32]));
      chk("avg_new", dut_avg(e[33:32]), e[31:0]);
    end else begin
      chk("no_valid", 32'(o_valid), 32'd0);
    end
    chk("avg0", o_avg0, exp_avg[0]);
    chk("avg1", o_avg1, exp_avg[1]);
    chk("avg2", o_avg2, exp_avg[2]);
    chk("avg3", o_avg3, exp_avg[3]);
    chk("sample_cnt", 32'(o_sample_cnt), 32'(m_cnt));
    chk("seq_err", 32'(o_seq_err), 32'(m_err));
`ifndef AIN_STALL_DET_EN
    chk("stall_off", 32'(o_stall), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("valid_pulse", 32'(o_valid), 32'd0);
  endtask

  task automatic random_code(output logic [23:0] code);
    code = 24'($urandom);
  endtask

  // Four legal steps; the sample of channel 'ch' gets 'code', others random.
  task automatic run_round(input logic [1:0] ch, input logic [23:0] code);
    logic [23:0] r;
    for (int s = 0; s < 4; s++) begin
      random_code(r);
      send_event(m_sm + 2'd1, (m_sm == ch) ? code : r);
    end
  endtask

  task automatic set_k(input int v);
    @(negedge clk);
    i_avg_log2 = 3'(v);
    if (clamp_k(v) != m_k) model_flush();
    m_k = clamp_k(v);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    model_flush();
    m_err = 1'b0;
    #1;
    chk("clear_seq_err", 32'(o_seq_err), 32'd0);
    chk("clear_cnt_hold", 32'(o_sample_cnt), 32'(m_cnt));
    chk("clear_avg_hold", o_avg2, exp_avg[2]);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_avg0"}, o_avg0, 32'd0);
    chk({tag, "_avg1"}, o_avg1, 32'd0);
    chk({tag, "_avg2"}, o_avg2, 32'd0);
    chk({tag, "_avg3"}, o_avg3, 32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_ch"}, 32'(o_ch), 32'd0);
    chk({tag, "_seq_err"}, 32'(o_seq_err), 32'd0);
    chk({tag, "_cnt"}, 32'(o_sample_cnt), 32'd0);
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    i_ain_sm = 2'd0;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] r;
    int          sel;
    rst_n      = 1'b0;
    i_ain_sm   = 2'd0;
    i_AIN0     = '0;
    i_AIN1     = '0;
    i_AIN2     = '0;
    i_AIN3     = '0;
    i_avg_log2 = 3'd0;
    i_clear    = 1'b0;
    m_k        = 0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // k=0 pass-through, positive full scale then negative full scale
    set_k(0);
    send_event(2'd1, 24'h7FFFFF);
    chk("tp_avg0_fs", o_avg0, 32'h007FFFFF);
    chk("tp_cnt1", 32'(o_sample_cnt), 32'd1);
    send_event(2'd2, 24'h800000);
    chk("tp_avg1_neg", o_avg1, 32'hFF800000);

    // k=2 on AIN2: 10,20,30,-4 -> 14 ; -5,-4,-4,-4 -> -5
    set_k(2);
    run_round(2'd2, 24'd10);
    run_round(2'd2, 24'd20);
    run_round(2'd2, 24'd30);
    run_round(2'd2, 24'hFFFFFC);
    chk("tp_avg2_14", o_avg2, 32'd14);
    run_round(2'd2, 24'hFFFFFB);
    run_round(2'd2, 24'hFFFFFC);
    run_round(2'd2, 24'hFFFFFC);
    run_round(2'd2, 24'hFFFFFC);
    chk("tp_avg2_floor", o_avg2, 32'hFFFFFFFB);

    // out-of-order step 0 -> 2, then clear
    while (m_sm != 2'd0) begin
      random_code(r);
      send_event(m_sm + 2'd1, r);
    end
    random_code(r);
    send_event(2'd2, r);
    chk("tp_seq_err_set", 32'(o_seq_err), 32'd1);
    pulse_clear();

    // two AIN3 samples at k=2, switch to k=1, then 6 and 8 -> 7
    random_code(r);
    run_round(2'd3, r);
    random_code(r);
    run_round(2'd3, r);
    set_k(1);
    run_round(2'd3, 24'd6);
    run_round(2'd3, 24'd8);
    chk("tp_avg3_7", o_avg3, 32'd7);

    // exponent above LOG2_MAX is clamped
    set_k(7);
    for (int i = 0; i < 4; i++) begin
      random_code(r);
      run_round(2'd0, r);
    end

    // randomized steps, codes, exponents and clears
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 19);
      random_code(r);
      if (sel == 0) set_k($urandom_range(0, 7));
      else if (sel == 1) send_event(m_sm + 2'($urandom_range(2, 3)), r);
      else if (sel == 2) pulse_clear();
      else send_event(m_sm + 2'd1, r);
    end

    // reset in the middle of a window; the next result needs a full window
    set_k(2);
    random_code(r);
    send_event(m_sm + 2'd1, r);
    random_code(r);
    send_event(m_sm + 2'd1, r);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      random_code(r);
      run_round(2'd1, r);
    end

`ifdef AIN_STALL_DET_EN
    repeat (50) @(negedge clk);
    #1;
    chk("stall_not_yet", 32'(o_stall), 32'd0);
    repeat (70) @(negedge clk);
    #1;
    chk("stall_set", 32'(o_stall), 32'd1);
    random_code(r);
    send_event(m_sm + 2'd1, r);
    chk("stall_cleared", 32'(o_stall), 32'd0);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
